// File: rtl/led_pattern_ctrl.sv
// LED bank sequencing controller.
// Steps an 8-bit LED register at a programmable rate in one of four modes
// (rotate-left, rotate-right, bounce, blink). Mode changes are applied at
// step boundaries. Pattern load and pause control are also provided.
module led_pattern_ctrl #(
  parameter int TICK_DIV = 2,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] mode_sel,
  input  logic       mode_load,
  input  logic [7:0] pattern_in,
  input  logic       pattern_load,
  input  logic [3:0] speed,
  input  logic       pause,
  output logic [7:0] leds,
  output logic       tick,
  output logic [1:0] mode,
  output logic       pending
);

  typedef enum logic [1:0] {
    ROT_L  = 2'b00,
    ROT_R  = 2'b01,
    BOUNCE = 2'b10,
    BLINK  = 2'b11
  } mode_e;

  typedef enum logic {
    RUN   = 1'b0,
    PAUSE = 1'b1
  } state_e;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } dir_e;

  state_e           state_q;
  mode_e            mode_q;
  mode_e            pmode_q;
  logic             pending_q;
  dir_e             dir_q;
  logic [CNT_W-1:0] count_q;
  logic [7:0]       leds_q;
  logic             tick_q;

  logic [CNT_W-1:0] limit_m1;
  logic             terminal;
  logic             run_active;
  logic             step_en;
  mode_e            eff_mode;
  dir_e             dir_eff;
  logic [7:0]       leds_d;
  dir_e             dir_d;

  // Step period tracks the live speed input, so a speed change takes effect
  // within the current period.
  assign limit_m1   = CNT_W'(TICK_DIV) * (CNT_W'(speed) + CNT_W'(1)) - CNT_W'(1);
  assign terminal   = (count_q >= limit_m1);
  // Pause freezes stepping on the very cycle it is seen, not one cycle late.
  assign run_active = (state_q == RUN) && !pause;
  assign step_en    = run_active && terminal;

  // Step function: next LED value and bounce direction using the effective mode.
  always_comb begin
    eff_mode = pending_q ? pmode_q : mode_q;
    // Entering bounce from another mode always starts moving left.
    dir_eff  = ((eff_mode == BOUNCE) && (mode_q != BOUNCE)) ? LEFT : dir_q;
    leds_d   = leds_q;
    dir_d    = dir_eff;
    case (eff_mode)
      ROT_L:  leds_d = {leds_q[6:0], leds_q[7]};
      ROT_R:  leds_d = {leds_q[0], leds_q[7:1]};
      BOUNCE: begin
        if (dir_eff == LEFT) begin
          if (leds_q[7]) begin
            dir_d  = RIGHT;
            leds_d = {leds_q[0], leds_q[7:1]};
          end else begin
            leds_d = {leds_q[6:0], leds_q[7]};
          end
        end else begin
          if (leds_q[0]) begin
            dir_d  = LEFT;
            leds_d = {leds_q[6:0], leds_q[7]};
          end else begin
            leds_d = {leds_q[0], leds_q[7:1]};
          end
        end
      end
      BLINK:  leds_d = ~leds_q;
      default: leds_d = leds_q;
    endcase
  end

  // Run/pause FSM with prescaler, LED register, mode sequencing and tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      mode_q    <= ROT_L;
      pmode_q   <= ROT_L;
      pending_q <= 1'b0;
      dir_q     <= LEFT;
      count_q   <= '0;
      leds_q    <= 8'b0001_1111;
      tick_q    <= 1'b0;
    end else begin
      case (state_q)
        RUN:     if (pause)  state_q <= PAUSE;
        PAUSE:   if (!pause) state_q <= RUN;
        default: state_q <= RUN;
      endcase

      tick_q <= 1'b0;
      if (run_active) begin
        count_q <= terminal ? '0 : count_q + CNT_W'(1);
      end

      // Pattern load wins over any step due this cycle.
      if (pattern_load) begin
        leds_q  <= pattern_in;
        count_q <= '0;
        dir_q   <= LEFT;
      end else if (step_en) begin
        leds_q    <= leds_d;
        dir_q     <= dir_d;
        mode_q    <= eff_mode;
        pending_q <= 1'b0;
        tick_q    <= 1'b1;
      end

      // A load coinciding with a step becomes pending for the following step.
      if (mode_load) begin
        pmode_q   <= mode_e'(mode_sel);
        pending_q <= 1'b1;
      end
    end
  end

  assign leds    = leds_q;
  assign tick    = tick_q;
  assign mode    = mode_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed testbench for led_pattern_ctrl (TICK_DIV=2).
module tb_led_pattern_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] mode_sel;
  logic       mode_load;
  logic [7:0] pattern_in;
  logic       pattern_load;
  logic [3:0] speed;
  logic       pause;
  logic [7:0] leds;
  logic       tick;
  logic [1:0] mode;
  logic       pending;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp1 [4];
  logic [7:0] exp2 [15];

  led_pattern_ctrl #(.TICK_DIV(2), .CNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mode_sel     (mode_sel),
    .mode_load    (mode_load),
    .pattern_in   (pattern_in),
    .pattern_load (pattern_load),
    .speed        (speed),
    .pause        (pause),
    .leds         (leds),
    .tick         (tick),
    .mode         (mode),
    .pending      (pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    exp1 = '{8'h3E, 8'h7C, 8'hF8, 8'hF1};
    exp2 = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
             8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

    rst_n = 1'b0; mode_sel = 2'b00; mode_load = 1'b0; pattern_in = 8'h00;
    pattern_load = 1'b0; speed = 4'd0; pause = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_leds", leds, 8'h1F);
    chk("rst_tick", {7'b0, tick}, 8'h00);
    chk("rst_mode", {6'b0, mode}, 8'h00);
    chk("rst_pending", {7'b0, pending}, 8'h00);

    // Scenario 1: default rotate-left, one step every 2 cycles
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("s1_idle_tick%0d", i), {7'b0, tick}, 8'h00);
      step();
      chk($sformatf("s1_leds%0d", i), leds, exp1[i]);
      chk($sformatf("s1_tick%0d", i), {7'b0, tick}, 8'h01);
    end

    // Scenario 2: pattern 01 with bounce
    pattern_in = 8'h01; pattern_load = 1'b1; mode_sel = 2'b10; mode_load = 1'b1;
    step();
    pattern_load = 1'b0; mode_load = 1'b0;
    chk("s2_load_leds", leds, 8'h01);
    chk("s2_load_tick", {7'b0, tick}, 8'h00);
    chk("s2_pending", {7'b0, pending}, 8'h01);
    chk("s2_mode_old", {6'b0, mode}, 8'h00);
    for (int i = 0; i < 15; i++) begin
      step();
      chk($sformatf("s2_idle_tick%0d", i), {7'b0, tick}, 8'h00);
      step();
      chk($sformatf("s2_leds%0d", i), leds, exp2[i]);
      chk($sformatf("s2_tick%0d", i), {7'b0, tick}, 8'h01);
      if (i == 0) begin
        chk("s2_mode_new", {6'b0, mode}, 8'h02);
        chk("s2_pending_clr", {7'b0, pending}, 8'h00);
      end
    end

    // Scenario 3: speed=3 gives an 8-cycle period; lowering speed mid-period
    speed = 4'd3;
    for (int i = 0; i < 7; i++) begin
      step();
      chk($sformatf("s3_wait_tick%0d", i), {7'b0, tick}, 8'h00);
    end
    step();
    chk("s3_leds_a", leds, 8'h04);
    chk("s3_tick_a", {7'b0, tick}, 8'h01);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("s3_wait2_tick%0d", i), {7'b0, tick}, 8'h00);
    end
    speed = 4'd0;
    step();
    chk("s3_leds_fast", leds, 8'h08);
    chk("s3_tick_fast", {7'b0, tick}, 8'h01);
    step();
    chk("s3_idle_fast", {7'b0, tick}, 8'h00);
    step();
    chk("s3_leds_b", leds, 8'h10);
    chk("s3_tick_b", {7'b0, tick}, 8'h01);

    // Scenario 4: blink requested mid-period (speed=1, 4-cycle period)
    speed = 4'd1;
    step();
    step();
    chk("s4_pre_tick", {7'b0, tick}, 8'h00);
    mode_sel = 2'b11; mode_load = 1'b1;
    step();
    mode_load = 1'b0;
    chk("s4_pending", {7'b0, pending}, 8'h01);
    chk("s4_mode_old", {6'b0, mode}, 8'h02);
    chk("s4_leds_hold", leds, 8'h10);
    step();
    chk("s4_leds_inv", leds, 8'hEF);
    chk("s4_tick", {7'b0, tick}, 8'h01);
    chk("s4_mode_new", {6'b0, mode}, 8'h03);
    chk("s4_pending_clr", {7'b0, pending}, 8'h00);
    step(); step(); step();
    chk("s4_idle_tick", {7'b0, tick}, 8'h00);
    // mode_load on the terminal edge: step still blinks, ROT_L goes pending
    mode_sel = 2'b00; mode_load = 1'b1;
    step();
    mode_load = 1'b0;
    chk("s4_simul_leds", leds, 8'h10);
    chk("s4_simul_tick", {7'b0, tick}, 8'h01);
    chk("s4_simul_mode", {6'b0, mode}, 8'h03);
    chk("s4_simul_pending", {7'b0, pending}, 8'h01);
    step(); step(); step();
    step();
    chk("s4_rotl_leds", leds, 8'h20);
    chk("s4_rotl_mode", {6'b0, mode}, 8'h00);
    chk("s4_rotl_pending", {7'b0, pending}, 8'h00);

    // Scenario 5: pause at count=1, pattern load while paused, resume
    speed = 4'd0;
    step();
    chk("s5_pre_tick", {7'b0, tick}, 8'h00);
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("s5_pause_tick%0d", i), {7'b0, tick}, 8'h00);
      chk($sformatf("s5_pause_leds%0d", i), leds, 8'h20);
    end
    pattern_in = 8'hA5; pattern_load = 1'b1;
    step();
    pattern_load = 1'b0;
    chk("s5_load_leds", leds, 8'hA5);
    chk("s5_load_tick", {7'b0, tick}, 8'h00);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("s5_pause2_tick%0d", i), {7'b0, tick}, 8'h00);
      chk($sformatf("s5_pause2_leds%0d", i), leds, 8'hA5);
    end
    pause = 1'b0;
    step();
    chk("s5_resume_tick0", {7'b0, tick}, 8'h00);
    step();
    chk("s5_resume_tick1", {7'b0, tick}, 8'h00);
    step();
    chk("s5_resume_leds", leds, 8'h4B);
    chk("s5_resume_tick", {7'b0, tick}, 8'h01);

    // Scenario 6: asynchronous reset with a pending mode change
    mode_sel = 2'b01; mode_load = 1'b1;
    step();
    mode_load = 1'b0;
    chk("s6_pending", {7'b0, pending}, 8'h01);
    #2 rst_n = 1'b0;
    #1;
    chk("s6_rst_leds", leds, 8'h1F);
    chk("s6_rst_mode", {6'b0, mode}, 8'h00);
    chk("s6_rst_pending", {7'b0, pending}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("s6_idle_tick", {7'b0, tick}, 8'h00);
    chk("s6_idle_leds", leds, 8'h1F);
    step();
    chk("s6_leds_a", leds, 8'h3E);
    chk("s6_tick_a", {7'b0, tick}, 8'h01);
    step(); step();
    chk("s6_leds_b", leds, 8'h7C);
    chk("s6_mode_b", {6'b0, mode}, 8'h00);

    // All-zero blink and all-one bounce
    pattern_in = 8'h00; pattern_load = 1'b1; mode_sel = 2'b11; mode_load = 1'b1;
    step();
    pattern_load = 1'b0; mode_load = 1'b0;
    step(); step();
    chk("s7_blink_ff", leds, 8'hFF);
    chk("s7_blink_mode", {6'b0, mode}, 8'h03);
    step(); step();
    chk("s7_blink_00", leds, 8'h00);
    pattern_in = 8'hFF; pattern_load = 1'b1; mode_sel = 2'b10; mode_load = 1'b1;
    step();
    pattern_load = 1'b0; mode_load = 1'b0;
    step(); step();
    chk("s7_bounce_ff_a", leds, 8'hFF);
    chk("s7_bounce_tick", {7'b0, tick}, 8'h01);
    step(); step();
    chk("s7_bounce_ff_b", leds, 8'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
